// File: rtl/chroma_pkg.sv
// Shared definitions for the chroma residual controller: FSM states,
// H.264 chroma intra mode codes and the default per-block SAD width.
package chroma_pkg;

  localparam int SAD_W_DEF = 14;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRED     = 3'd1,
    S_RES      = 3'd2,
    S_WAIT_SAD = 3'd3,
    S_DECIDE   = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // PLANE is a valid H.264 code but is never evaluated by this block.
  localparam logic [1:0] MODE_DC    = 2'd0;
  localparam logic [1:0] MODE_H     = 2'd1;
  localparam logic [1:0] MODE_V     = 2'd2;
  localparam logic [1:0] MODE_PLANE = 2'd3;

endpackage

// File: rtl/chroma_mode_sel.sv
// Combinational chroma mode decision: smallest accumulated SAD among the
// legal candidates, ties resolved towards the lower mode code.
module chroma_mode_sel
  import chroma_pkg::*;
#(
  parameter int ACC_W = SAD_W_DEF + 1
) (
  input  logic [ACC_W-1:0] v_sum,
  input  logic [ACC_W-1:0] h_sum,
  input  logic [ACC_W-1:0] dc_sum,
  input  logic             avail_top,
  input  logic             avail_left,
  output logic [1:0]       mode,
  output logic [ACC_W-1:0] sad
);

  // Strict less-than keeps the earlier (lower-code) candidate on a tie.
  always_comb begin
    mode = MODE_DC;
    sad  = dc_sum;
    if (avail_left && (h_sum < sad)) begin
      mode = MODE_H;
      sad  = h_sum;
    end
    if (avail_top && (v_sum < sad)) begin
      mode = MODE_V;
      sad  = v_sum;
    end
  end

endmodule

// File: rtl/chroma_res_ctrl.sv
// Sequences predictor load and residual generation for Cb then Cr,
// accumulates the per-mode SADs and registers the best chroma mode.
module chroma_res_ctrl
  import chroma_pkg::*;
#(
  parameter int SAD_W = SAD_W_DEF,
  parameter int ACC_W = SAD_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             avail_top,
  input  logic             avail_left,
  input  logic [SAD_W-1:0] vsad,
  input  logic [SAD_W-1:0] hsad,
  input  logic [SAD_W-1:0] dcsad,
  input  logic             sad_valid,
  output logic             load_pred,
  output logic             res_en,
  output logic             comp_sel,
  output logic             busy,
  output logic             done,
  output logic [1:0]       best_mode,
  output logic [ACC_W-1:0] best_sad,
  output logic [2:0]       dbg_state
);

  // Handshake: start is a request taken only in IDLE; sad_valid is a
  // one-way valid with no ready, consumed only in WAIT_SAD, ignored elsewhere.

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_v, acc_h, acc_dc;
  logic             top_q, left_q;
  logic [1:0]       sel_mode;
  logic [ACC_W-1:0] sel_sad;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_pred = 1'b0;
    res_en    = 1'b0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:     if (start) state_d = S_PRED;
      S_PRED: begin
        load_pred = 1'b1;
        state_d   = S_RES;
      end
      S_RES: begin
        res_en  = 1'b1;
        state_d = S_WAIT_SAD;
      end
      S_WAIT_SAD: if (sad_valid) state_d = comp_sel ? S_DECIDE : S_PRED;
      S_DECIDE:   state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_v     <= '0;
      acc_h     <= '0;
      acc_dc    <= '0;
      top_q     <= 1'b0;
      left_q    <= 1'b0;
      comp_sel  <= 1'b0;
      best_mode <= MODE_DC;
      best_sad  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_v    <= '0;
            acc_h    <= '0;
            acc_dc   <= '0;
            top_q    <= avail_top;
            left_q   <= avail_left;
            comp_sel <= 1'b0;
          end
        end
        S_WAIT_SAD: begin
          if (sad_valid) begin
            acc_v  <= acc_v  + ACC_W'(vsad);
            acc_h  <= acc_h  + ACC_W'(hsad);
            acc_dc <= acc_dc + ACC_W'(dcsad);
            if (!comp_sel) comp_sel <= 1'b1;
          end
        end
        S_DECIDE: begin
          best_mode <= sel_mode;
          best_sad  <= sel_sad;
        end
        default: ;
      endcase
    end
  end

  chroma_mode_sel #(.ACC_W(ACC_W)) u_mode_sel (
    .v_sum      (acc_v),
    .h_sum      (acc_h),
    .dc_sum     (acc_dc),
    .avail_top  (top_q),
    .avail_left (left_q),
    .mode       (sel_mode),
    .sad        (sel_sad)
  );

  assign dbg_state = state_q;

endmodule

// File: tb/tb_chroma_res_ctrl.sv
// Self-checking bench for chroma_res_ctrl: scenario tasks drive operations,
// expected mode/SAD/latency are queued at start and compared at done.
module tb_chroma_res_ctrl;
  import chroma_pkg::*;

  localparam int SAD_W = 14;
  localparam int ACC_W = 15;
  localparam int EW    = ACC_W + 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             avail_top = 1'b0;
  logic             avail_left = 1'b0;
  logic [SAD_W-1:0] vsad = '0;
  logic [SAD_W-1:0] hsad = '0;
  logic [SAD_W-1:0] dcsad = '0;
  logic             sad_valid = 1'b0;
  logic             load_pred, res_en, comp_sel, busy, done;
  logic [1:0]       best_mode;
  logic [ACC_W-1:0] best_sad;
  logic [2:0]       dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int lp_cnt = 0;
  int done_cnt = 0;
  logic [1:0]       last_mode = 2'd0;
  logic [ACC_W-1:0] last_sad = '0;

  logic [EW-1:0] exp_q[$];
  int            lat_q[$];

  chroma_res_ctrl #(.SAD_W(SAD_W), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .avail_top  (avail_top),
    .avail_left (avail_left),
    .vsad       (vsad),
    .hsad       (hsad),
    .dcsad      (dcsad),
    .sad_valid  (sad_valid),
    .load_pred  (load_pred),
    .res_en     (res_en),
    .comp_sel   (comp_sel),
    .busy       (busy),
    .done       (done),
    .best_mode  (best_mode),
    .best_sad   (best_sad),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (load_pred) lp_cnt++;
    if (done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input int v, input int h, input int dc,
                                          input bit at, input bit al);
    int best;
    logic [1:0] m;
    best = dc;
    m    = 2'd0;
    if (al && h < best) begin best = h; m = 2'd1; end
    if (at && v < best) begin best = v; m = 2'd2; end
    return {m, ACC_W'(best)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_block(input int v, input int h, input int dc,
                             input int dly, input bit blk);
    for (int i = 0; i < 50 && !res_en; i++) @(negedge clk);
    total_cnt++;
    if (res_en !== 1'b1) $display("FAIL res_en_wait: res_en=%b required 1", res_en);
    else pass_cnt++;
    total_cnt++;
    if (comp_sel !== blk) $display("FAIL comp_sel: got %b required %b", comp_sel, blk);
    else pass_cnt++;
    repeat (dly) @(negedge clk);
    @(negedge clk);
    sad_valid = 1'b1;
    vsad  = SAD_W'(v);
    hsad  = SAD_W'(h);
    dcsad = SAD_W'(dc);
    @(negedge clk);
    sad_valid = 1'b0;
    vsad  = SAD_W'($urandom_range(0, 16383));
    hsad  = SAD_W'($urandom_range(0, 16383));
    dcsad = SAD_W'($urandom_range(0, 16383));
  endtask

  // Runs one full operation; stray=1 also pulses sad_valid in the start cycle.
  task automatic run_op(input int v0, input int h0, input int dc0,
                        input int v1, input int h1, input int dc1,
                        input bit at, input bit al, input int d0, input int d1,
                        input bit hold, input bit stray);
    logic [EW-1:0] exp;
    int exp_lat;
    int start_cyc;
    exp_q.push_back(model(v0 + v1, h0 + h1, dc0 + dc1, at, al));
    lat_q.push_back(8 + d0 + d1);
    start = 1'b1;
    avail_top = at;
    avail_left = al;
    if (stray) begin
      sad_valid = 1'b1;
      vsad  = '0;
      hsad  = SAD_W'(500);
      dcsad = SAD_W'(500);
    end
    @(negedge clk);
    start_cyc = cyc;
    sad_valid = 1'b0;
    if (!hold) start = 1'b0;
    avail_top  = 1'($urandom_range(0, 1));
    avail_left = 1'($urandom_range(0, 1));
    total_cnt++;
    if (best_mode !== last_mode || best_sad !== last_sad)
      $display("FAIL best_hold: got %0d/%0d required %0d/%0d",
               best_mode, best_sad, last_mode, last_sad);
    else pass_cnt++;
    drive_block(v0, h0, dc0, d0, 1'b0);
    drive_block(v1, h1, dc1, d1, 1'b1);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    exp = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    total_cnt++;
    if (done !== 1'b1) begin
      $display("FAIL done_wait: done=%b required 1", done);
    end else begin
      pass_cnt++;
      total_cnt++;
      if (best_mode !== exp[EW-1:ACC_W])
        $display("FAIL best_mode: got %0d required %0d", best_mode, exp[EW-1:ACC_W]);
      else pass_cnt++;
      total_cnt++;
      if (best_sad !== exp[ACC_W-1:0])
        $display("FAIL best_sad: got %0d required %0d", best_sad, exp[ACC_W-1:0]);
      else pass_cnt++;
      total_cnt++;
      if (cyc - start_cyc + 1 != exp_lat)
        $display("FAIL latency: got %0d required %0d", cyc - start_cyc + 1, exp_lat);
      else pass_cnt++;
    end
    last_mode = exp[EW-1:ACC_W];
    last_sad  = exp[ACC_W-1:0];
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL after_done: done=%b busy=%b required 0/0", done, busy);
    else pass_cnt++;
    start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    sad_valid = 1'b1;
    vsad = '1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, load_pred, res_en, comp_sel} !== 5'b0 || best_mode !== 2'd0 || best_sad !== '0)
      $display("FAIL reset_state: busy=%b done=%b lp=%b res=%b cs=%b mode=%0d sad=%0d required all 0",
               busy, done, load_pred, res_en, comp_sel, best_mode, best_sad);
    else pass_cnt++;
    reset = 1'b0;
    start = 1'b0;
    sad_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || load_pred !== 1'b0)
      $display("FAIL post_reset_idle: busy=%b load_pred=%b required 0/0", busy, load_pred);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    run_op(100, 200, 300, 50, 60, 70, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_no_top;
    run_op(100, 200, 300, 50, 60, 70, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_tie;
    run_op(40, 40, 40, 40, 40, 40, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_delayed_and_stray;
    @(negedge clk);
    sad_valid = 1'b1;
    vsad = SAD_W'(7);
    hsad = SAD_W'(9000);
    dcsad = SAD_W'(9000);
    @(negedge clk);
    sad_valid = 1'b0;
    run_op(100, 90, 95, 100, 90, 95, 1'b1, 1'b1, 5, 5, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    avail_top = 1'b1;
    avail_left = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_block(10, 20, 30, 0, 1'b0);
    for (int i = 0; i < 50 && !res_en; i++) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || best_mode !== 2'd0 || best_sad !== '0 || dbg_state !== 3'(S_IDLE))
      $display("FAIL reset_mid: busy=%b mode=%0d sad=%0d state=%0d required 0/0/0/0",
               busy, best_mode, best_sad, dbg_state);
    else pass_cnt++;
    reset = 1'b0;
    last_mode = 2'd0;
    last_sad  = '0;
    run_op(300, 20, 100, 300, 20, 100, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_hold_start;
    int lp0, dn0;
    @(negedge clk);
    lp0 = lp_cnt;
    dn0 = done_cnt;
    run_op(5, 6, 7, 8, 9, 1, 1'b1, 1'b0, 0, 2, 1'b1, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (lp_cnt - lp0 != 2 || done_cnt - dn0 != 1)
      $display("FAIL hold_start: load_pred=%0d done=%0d required 2/1", lp_cnt - lp0, done_cnt - dn0);
    else pass_cnt++;
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++)
      run_op($urandom_range(0, 2000), $urandom_range(0, 2000), $urandom_range(0, 2000),
             $urandom_range(0, 2000), $urandom_range(0, 2000), $urandom_range(0, 2000),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
    run_op(16383, 16383, 16383, 16383, 16383, 16383, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    run_op(16383, 16382, 16383, 16383, 16383, 16383, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_top();
    test_reset_mid();
    test_tie();
    test_delayed_and_stray();
    test_hold_start();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
